march_bist_sequencer: RTL and testbench



---
 rtl/bist_pkg.sv | 27 ++
 rtl/bist_addr_counter.sv | 31 +++
 rtl/march_bist_sequencer.sv | 167 ++++++++++++++++
 tb/tb_march_bist_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the March C- BIST sequencer: state encoding and the
// per-element operation table.
package bist_pkg;

  localparam int ELEM_W = 3;

  // Element states encode their element index in the low bits, so M0..M5 = 0..5
  typedef enum logic [3:0] {
    M0    = 4'd0,
    M1    = 4'd1,
    M2    = 4'd2,
    M3    = 4'd3,
    M4    = 4'd4,
    M5    = 4'd5,
    FLUSH = 4'd6,
    DONE  = 4'd7,
    IDLE  = 4'd8
  } state_t;

  // Element table: bit e describes element e
  localparam logic [7:0] ELEM_DOWN      = 8'b0001_1000;
  localparam logic [7:0] ELEM_HAS_READ  = 8'b0011_1110;
  localparam logic [7:0] ELEM_HAS_WRITE = 8'b0001_1111;
  localparam logic [7:0] ELEM_READ_ONE  = 8'b0001_0100;
  localparam logic [7:0] ELEM_WRITE_ONE = 8'b0000_1010;

endpackage

// File: rtl/bist_addr_counter.sv
// Loadable up/down address counter; terminal flags the last address in the
// current counting direction.
module bist_addr_counter #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  input  logic              up_down,
  output logic [ADDR_W-1:0] addr,
  output logic              terminal
);

  logic [ADDR_W-1:0] addr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg <= '0;
    end else if (load) begin
      addr_reg <= load_val;
    end else if (en) begin
      addr_reg <= up_down ? addr_reg + ADDR_W'(1) : addr_reg - ADDR_W'(1);
    end
  end

  assign addr     = addr_reg;
  assign terminal = up_down ? (addr_reg == '1) : (addr_reg == '0);

endmodule

// File: rtl/march_bist_sequencer.sv
// March C- BIST engine: drives a single-port RAM through the six March elements
// and checks read data through a one-stage compare pipeline.
module march_bist_sequencer
  import bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ELEM_W-1:0] fail_elem,
  output logic [CNT_W-1:0]  fail_count
);

  state_t state_reg, state_next;
  logic   op_reg, op_next;

  logic [ELEM_W-1:0] elem, elem_nx;
  logic              in_elem, has_read, has_write, is_read, is_write, last_op;
  logic              up_down, start_ok;
  logic              cnt_load, cnt_en, terminal;
  logic [ADDR_W-1:0] cnt_load_val, addr;

  logic              cmp_valid_reg;
  logic [DATA_W-1:0] exp_data_reg;
  logic [ADDR_W-1:0] exp_addr_reg;
  logic [ELEM_W-1:0] exp_elem_reg;
  logic              mismatch;

  logic              fail_reg;
  logic [ADDR_W-1:0] fail_addr_reg;
  logic [ELEM_W-1:0] fail_elem_reg;
  logic [CNT_W-1:0]  fail_count_reg;

  assign elem      = state_reg[ELEM_W-1:0];
  assign elem_nx   = elem + ELEM_W'(1);
  assign in_elem   = (state_reg <= M5);
  assign has_read  = in_elem && ELEM_HAS_READ[elem];
  assign has_write = in_elem && ELEM_HAS_WRITE[elem];
  // Two-op elements read when op=0 and write when op=1
  assign is_read   = has_read && !(has_write && op_reg);
  assign is_write  = has_write && !(has_read && !op_reg);
  assign last_op   = !(has_read && has_write) || op_reg;
  assign up_down   = !ELEM_DOWN[elem];
  assign busy      = in_elem || (state_reg == FLUSH);
  assign done      = (state_reg == DONE);
  assign start_ok  = ((state_reg == IDLE) || (state_reg == DONE)) && start && !abort;

  bist_addr_counter #(.ADDR_W(ADDR_W)) u_addr_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .up_down  (up_down),
    .addr     (addr),
    .terminal (terminal)
  );

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start_ok) begin
          state_next = M0;
          op_next    = 1'b0;
          cnt_load   = 1'b1;
        end
      end
      FLUSH: state_next = abort ? IDLE : DONE;
      M0, M1, M2, M3, M4, M5: begin
        if (abort) begin
          state_next = IDLE;
          op_next    = 1'b0;
        end else if (!last_op) begin
          op_next = 1'b1;
        end else begin
          op_next = 1'b0;
          if (terminal) begin
            state_next   = state_t'(state_reg + 4'd1);
            cnt_load     = 1'b1;
            cnt_load_val = ELEM_DOWN[elem_nx] ? '1 : '0;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
    end
  end

  // A read issued in the abort cycle never gets compared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid_reg <= 1'b0;
      exp_data_reg  <= '0;
      exp_addr_reg  <= '0;
      exp_elem_reg  <= '0;
    end else begin
      cmp_valid_reg <= is_read && !abort;
      if (is_read) begin
        exp_data_reg <= {DATA_W{ELEM_READ_ONE[elem]}};
        exp_addr_reg <= addr;
        exp_elem_reg <= elem;
      end
    end
  end

  assign mismatch = cmp_valid_reg && (rd_data != exp_data_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_reg       <= 1'b0;
      fail_addr_reg  <= '0;
      fail_elem_reg  <= '0;
      fail_count_reg <= '0;
    end else if (start_ok) begin
      fail_reg       <= 1'b0;
      fail_addr_reg  <= '0;
      fail_elem_reg  <= '0;
      fail_count_reg <= '0;
    end else if (mismatch) begin
      if (fail_count_reg != '1) fail_count_reg <= fail_count_reg + CNT_W'(1);
      if (!fail_reg) begin
        fail_reg      <= 1'b1;
        fail_addr_reg <= exp_addr_reg;
        fail_elem_reg <= exp_elem_reg;
      end
    end
  end

  assign mem_addr   = in_elem ? addr : '0;
  assign mem_wdata  = is_write ? {DATA_W{ELEM_WRITE_ONE[elem]}} : '0;
  assign mem_we     = is_write;
  assign mem_re     = is_read;
  assign fail       = fail_reg;
  assign fail_addr  = fail_addr_reg;
  assign fail_elem  = fail_elem_reg;
  assign fail_count = fail_count_reg;

endmodule

// File: tb/tb_march_bist_sequencer.sv
// Bench for march_bist_sequencer: RAM model with injectable stuck-at faults and
// a scoreboard of the expected March C- operation trace.
module tb_march_bist_sequencer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int N      = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we, mem_re, busy, done, fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [CNT_W-1:0]  fail_count;

  always #5 clk = ~clk;

  march_bist_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .rd_data    (rd_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem),
    .fail_count (fail_count)
  );

  // RAM model; faults are applied on the read path
  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] sa1 [N];
  logic [DATA_W-1:0] sa0 [N];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) rd_data <= (mem[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt, n_reads, n_w0;
  logic [13:0] q[$];
  bit ended;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] op_word(input logic we, input logic re,
                                          input logic [3:0] a, input logic [7:0] d);
    return {we, re, a, (we ? d : 8'h00)};
  endfunction

  function automatic logic [31:0] all_outs();
    return {mem_addr, mem_wdata, mem_we, mem_re, busy, done, fail, fail_addr, fail_elem, fail_count};
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      sa1[i] = '0;
      sa0[i] = '0;
    end
  endtask

  // Expected trace: {w0 up}{r0,w1 up}{r1,w0 up}{r0,w1 down}{r1,w0 down}{r0 up}
  task automatic push_march();
    q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        logic [3:0] a;
        a = (e == 3 || e == 4) ? 4'(N - 1 - k) : 4'(k);
        if (e != 0) q.push_back(op_word(1'b0, 1'b1, a, 8'h00));
        if (e != 5) q.push_back(op_word(1'b1, 1'b0, a, (e == 1 || e == 3) ? 8'hFF : 8'h00));
      end
    end
  endtask

  task automatic begin_run();
    push_march();
    busy_cnt = 0;
    n_reads  = 0;
    n_w0     = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_clears", {busy, done, fail, fail_count}, {1'b1, 1'b0, 1'b0, 8'h00});
  endtask

  task automatic run_body(input int inj_start_at, input int abort_at, input int rst_at);
    ended = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        ended = 1'b1;
        break;
      end
      if (busy) begin
        logic [13:0] exp_op;
        busy_cnt++;
        exp_op = (q.size() > 0) ? q.pop_front() : 14'h0;
        check_eq("op", op_word(mem_we, mem_re, mem_addr, mem_wdata), exp_op);
        if (mem_re) n_reads++;
        if (mem_we && busy_cnt <= N && mem_wdata == 8'h00) n_w0++;
      end
      if (busy_cnt == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_idle", {busy, done, mem_we, mem_re}, 4'b0000);
        q.delete();
        return;
      end
      if (busy_cnt == rst_at) begin
        check_eq("fail_before_rst", {fail, fail_addr}, {1'b1, 4'd3});
        #1 rst = 1'b1;
        #1 check_eq("rst_async", all_outs(), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        return;
      end
      start = (busy_cnt == inj_start_at);
      @(negedge clk);
    end
  endtask

  task automatic finish_run(input string name, input logic exp_fail, input logic [3:0] exp_addr,
                            input logic [2:0] exp_elem, input logic [7:0] exp_cnt);
    check_eq({name, "_done_seen"}, ended, 1'b1);
    check_eq({name, "_busy_cycles"}, busy_cnt, 161);
    check_eq({name, "_trace_left"}, q.size(), 0);
    check_eq({name, "_reads"}, n_reads, 80);
    check_eq({name, "_w0_in_m0"}, n_w0, 16);
    check_eq({name, "_status"}, {done, busy, mem_we, mem_re, fail, fail_addr, fail_elem, fail_count},
             {1'b1, 1'b0, 1'b0, 1'b0, exp_fail, exp_addr, exp_elem, exp_cnt});
    $display("run %s: busy=%0d reads=%0d fail=%0b addr=%0d elem=%0d count=%0d",
             name, busy_cnt, n_reads, fail, fail_addr, fail_elem, fail_count);
  endtask

  initial begin
    clear_faults();
    repeat (3) @(negedge clk);
    check_eq("reset_outs", all_outs(), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_outs", all_outs(), 32'h0);

    // Fault-free run
    begin_run();
    run_body(-1, -1, -1);
    finish_run("clean", 1'b0, 4'd0, 3'd0, 8'd0);

    // Stuck-at-1 on bit0 of address 5: fails in M1, M3, M5
    sa1[5] = 8'h01;
    begin_run();
    run_body(-1, -1, -1);
    finish_run("sa1_a5", 1'b1, 4'd5, 3'd1, 8'd3);

    // Two faults: address 3 fails first (M1), address 9 fails in M2/M4
    clear_faults();
    sa0[9] = 8'h80;
    sa1[3] = 8'h01;
    begin_run();
    run_body(-1, -1, -1);
    finish_run("two_faults", 1'b1, 4'd3, 3'd1, 8'd5);

    // Restart from DONE with fail set; start pulse during M2 must be ignored
    clear_faults();
    begin_run();
    run_body(65, -1, -1);
    finish_run("restart_start_in_m2", 1'b0, 4'd0, 3'd0, 8'd0);

    // Abort mid-M3; fail status from M1 must be held
    sa1[5] = 8'h01;
    begin_run();
    run_body(-1, 95, -1);
    check_eq("abort_fail_held", {fail, fail_addr, fail_elem, fail_count}, {1'b1, 4'd5, 3'd1, 8'd1});
    repeat (3) @(negedge clk);
    check_eq("abort_stays_idle", {busy, done, mem_we, mem_re}, 4'b0000);
    $display("run abort_m3: busy=%0d fail=%0b count=%0d", busy_cnt, fail, fail_count);

    // abort together with start in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_eq("abort_beats_start", {busy, done, fail, fail_count}, {1'b0, 1'b0, 1'b1, 8'd1});
    @(negedge clk);
    check_eq("abort_beats_start_2", busy, 1'b0);
    $display("run abort_start_idle: busy=%0b fail=%0b", busy, fail);

    // Async reset mid-M1 after a failure has been recorded
    clear_faults();
    sa1[3] = 8'h01;
    begin_run();
    run_body(-1, -1, 28);
    check_eq("post_rst_idle", all_outs(), 32'h0);
    $display("run rst_m1: busy=%0d outs=%0h", busy_cnt, all_outs());

    // Recovery after reset
    clear_faults();
    begin_run();
    run_body(-1, -1, -1);
    finish_run("after_rst", 1'b0, 4'd0, 3'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
